// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared 640x480 VGA timing constants, state type and frame-buffer
//            address layout used by both the capture and display paths.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int unsigned c_H_ACTIVE = 640;
    localparam int unsigned c_V_ACTIVE = 480;
    localparam int unsigned c_H_TOTAL  = 800;
    localparam int unsigned c_V_TOTAL  = 525;
    localparam int unsigned c_ADDR_W   = 19;
    localparam int unsigned c_DATA_W   = 24;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } cap_state_t;

    function automatic logic [c_ADDR_W-1:0] vga_addr(input logic [9:0] h,
                                                     input logic [8:0] v);
        return {h, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_edge
// Brief    : Input register, previous copy and falling-edge detect for
//            HSYNC, VSYNC and BLANK_N.
// Revision : 1.0
// ============================================================================
module vga_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hsync_i,
    input  logic vsync_i,
    input  logic blank_n_i,
    output logic blank_n_o,
    output logic hs_fall_o,
    output logic vs_fall_o,
    output logic blank_fall_o
);

    // Bit order {hsync, vsync, blank_n}; idle levels avoid a false edge after reset
    localparam logic [2:0] c_IDLE = 3'b110;

    logic [2:0] s_q;
    logic [2:0] p_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q <= c_IDLE;
            p_q <= c_IDLE;
        end else begin
            s_q <= {hsync_i, vsync_i, blank_n_i};
            p_q <= s_q;
        end
    end

    assign blank_n_o    = s_q[0];
    assign hs_fall_o    = !s_q[2] && p_q[2];
    assign vs_fall_o    = !s_q[1] && p_q[1];
    assign blank_fall_o = !s_q[0] && p_q[0];

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture
// Brief    : VGA frame-capture receiver: recovers pixel coordinates, writes
//            active pixels to a frame buffer and checks per-frame timing.
// Revision : 1.0
// ============================================================================
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = c_H_ACTIVE,
    parameter int unsigned V_ACTIVE = c_V_ACTIVE,
    parameter int unsigned H_TOTAL  = c_H_TOTAL,
    parameter int unsigned V_TOTAL  = c_V_TOTAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_en,
    input  logic                VGA_HSYNC,
    input  logic                VGA_VSYNC,
    input  logic                VGA_BLANK_N,
    input  logic [7:0]          VGA_R,
    input  logic [7:0]          VGA_G,
    input  logic [7:0]          VGA_B,
    output logic                wr_en,
    output logic [c_ADDR_W-1:0] wr_addr,
    output logic [c_DATA_W-1:0] wr_data,
    output logic                frame_done,
    output logic                frame_err,
    output logic                locked
);

    localparam logic [9:0]  c_H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACT = 10'(V_ACTIVE);
    localparam logic [10:0] c_H_TOT = 11'(H_TOTAL);
    localparam logic [9:0]  c_V_TOT = 10'(V_TOTAL);

    logic w_s_blank, w_hs_fall, w_vs_fall, w_blank_fall;

    vga_sync_edge u_sync_edge (
        .clk_i        (clk),
        .rst_ni       (rst),
        .hsync_i      (VGA_HSYNC),
        .vsync_i      (VGA_VSYNC),
        .blank_n_i    (VGA_BLANK_N),
        .blank_n_o    (w_s_blank),
        .hs_fall_o    (w_hs_fall),
        .vs_fall_o    (w_vs_fall),
        .blank_fall_o (w_blank_fall)
    );

    cap_state_t          state_q;
    logic [c_DATA_W-1:0] rgb_q;
    logic [9:0]          h_q, v_q, line_q;
    logic [10:0]         period_q;
    logic                err_q, first_q;
    logic                wr_en_q, frame_done_q, frame_err_q, locked_q;
    logic [c_ADDR_W-1:0] wr_addr_q;
    logic [c_DATA_W-1:0] wr_data_q;

    logic w_frame_ok, w_period_err;
    assign w_frame_ok   = !err_q && (v_q == c_V_ACT) && (line_q == c_V_TOT);
    assign w_period_err = w_hs_fall && !first_q && (period_q != c_H_TOT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rgb_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            line_q       <= '0;
            period_q     <= '0;
            err_q        <= 1'b0;
            first_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rgb_q        <= {VGA_R, VGA_G, VGA_B};
            // Period counter reads H_TOTAL at a fall exactly one line after the last
            if (w_hs_fall) begin
                period_q <= 11'd1;
            end else if (period_q != '1) begin
                period_q <= period_q + 11'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_vs_fall && capture_en) begin
                        state_q  <= ST_CAPTURE;
                        h_q      <= '0;
                        v_q      <= '0;
                        line_q   <= {9'd0, w_hs_fall};
                        period_q <= '0;
                        err_q    <= 1'b0;
                        first_q  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_hs_fall) begin
                        first_q <= 1'b0;
                    end
                    if (w_vs_fall) begin
                        // Judge the finished frame on pre-update counters; a coincident
                        // line start is the first line of the new frame
                        frame_done_q <= w_frame_ok;
                        frame_err_q  <= !w_frame_ok;
                        locked_q     <= w_frame_ok;
                        h_q          <= '0;
                        v_q          <= '0;
                        line_q       <= {9'd0, w_hs_fall};
                        err_q        <= w_period_err;
                        if (!capture_en) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        if (w_hs_fall) begin
                            if (line_q != '1) begin
                                line_q <= line_q + 10'd1;
                            end
                            if (w_period_err) begin
                                err_q <= 1'b1;
                            end
                        end
                        if (w_s_blank) begin
                            if (h_q < c_H_ACT) begin
                                if (v_q < c_V_ACT) begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= vga_addr(h_q, v_q[8:0]);
                                    wr_data_q <= rgb_q;
                                end
                                h_q <= h_q + 10'd1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (w_blank_fall) begin
                            if (h_q != c_H_ACT) begin
                                err_q <= 1'b1;
                            end
                            if (v_q != c_V_ACT) begin
                                v_q <= v_q + 10'd1;
                            end
                            h_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign locked     = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_capture
// Brief    : Scoreboard bench for vga_capture on a scaled-down VGA raster.
// Revision : 1.0
// ============================================================================
module tb_vga_capture;

    localparam int HA       = 16;
    localparam int VA       = 6;
    localparam int HT       = 24;
    localparam int VT       = 10;
    localparam int HS0      = 18;
    localparam int HS1      = 21;
    localparam int VS0      = 7;
    localparam int VS_START = VS0 * HT + HS0;
    localparam int VS_END   = (VS0 + 1) * HT + HS0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        capture_en = 1'b0;
    logic        hs = 1'b1, vs = 1'b1, bl = 1'b0;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic        wr_en, frame_done, frame_err, locked;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;

    vga_capture #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .VGA_HSYNC   (hs),
        .VGA_VSYNC   (vs),
        .VGA_BLANK_N (bl),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
        int          cyc;
    } wexp_t;

    typedef struct {
        bit ok;
        int cyc;
    } fexp_t;

    wexp_t wq[$];
    fexp_t fq[$];
    wexp_t me;
    fexp_t mf;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int n_wr   = 0;
    int pushed = 0;
    bit capturing  = 1'b0;
    bit locked_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or frame pulse
    always @(negedge clk) begin
        if (rst) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                me = wq.pop_front();
                total++; bad++;
                $display("FAIL wr_missing: got none expected addr=%h at cycle %0d", me.addr, me.cyc);
            end
            if (wr_en) begin
                total++;
                n_wr++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h at cycle %0d expected no write",
                             wr_addr, wr_data, cyc);
                end else begin
                    me = wq.pop_front();
                    if (wr_addr !== me.addr || wr_data !== me.data || cyc != me.cyc) begin
                        bad++;
                        $display("FAIL wr: got addr=%h data=%h cycle=%0d expected addr=%h data=%h cycle=%0d",
                                 wr_addr, wr_data, cyc, me.addr, me.data, me.cyc);
                    end
                end
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                me = wq.pop_front();
                total++; bad++;
                $display("FAIL wr_missing: got none expected addr=%h at cycle %0d", me.addr, me.cyc);
            end

            while (fq.size() > 0 && fq[0].cyc < cyc) begin
                mf = fq.pop_front();
                total++; bad++;
                $display("FAIL frame_missing: got no pulse expected ok=%0d at cycle %0d", mf.ok, mf.cyc);
            end
            if (frame_done || frame_err) begin
                total++;
                if (fq.size() == 0) begin
                    bad++;
                    $display("FAIL frame_unexpected: got done=%b err=%b at cycle %0d expected none",
                             frame_done, frame_err, cyc);
                end else begin
                    mf = fq.pop_front();
                    if (frame_done !== mf.ok || frame_err !== !mf.ok || locked !== mf.ok || cyc != mf.cyc) begin
                        bad++;
                        $display("FAIL frame: got done=%b err=%b locked=%b cycle=%0d expected done=%b err=%b locked=%b cycle=%0d",
                                 frame_done, frame_err, locked, cyc, mf.ok, !mf.ok, mf.ok, mf.cyc);
                    end
                end
            end else if (fq.size() > 0 && fq[0].cyc == cyc) begin
                mf = fq.pop_front();
                total++; bad++;
                $display("FAIL frame_missing: got no pulse expected ok=%0d at cycle %0d", mf.ok, mf.cyc);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_err, locked}, 64'd0);
        pushed -= wq.size();
        wq.delete();
        fq.delete();
        capturing  = 1'b0;
        locked_exp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // One raster frame; VSYNC falls together with the HSYNC of line VS0
    task automatic drive_frame(input bit cen, input int long_row, input int short_row,
                               input int rst_row, input bit pat);
        bit          frame_bad;
        int          wr0, push0, p;
        logic [23:0] d;
        wexp_t       we;
        fexp_t       fe;
        frame_bad  = (long_row >= 0) || (short_row >= 0);
        wr0        = n_wr;
        push0      = pushed;
        capture_en = cen;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (v == short_row && h == HT - 1) continue;
                @(posedge clk);
                #2;
                if (v == rst_row && h == HA / 2) do_reset();
                p  = v * HT + h;
                hs = !(h >= HS0 && h < HS1);
                vs = !(p >= VS_START && p < VS_END);
                bl = (v < VA) && (h < HA || (v == long_row && h == HA));
                d  = pat ? {h[7:0], v[7:0], 8'h5A} : 24'($urandom);
                {r, g, b} = d;
                if (capturing && bl && h < HA) begin
                    we.addr = 19'((h << 9) | v);
                    we.data = d;
                    we.cyc  = cyc + 2;
                    wq.push_back(we);
                    pushed++;
                end
                if (p == VS_START) begin
                    if (capturing) begin
                        fe.ok  = !frame_bad;
                        fe.cyc = cyc + 2;
                        fq.push_back(fe);
                        locked_exp = !frame_bad;
                    end
                    capturing = cen;
                end
            end
        end
        check("frame_writes", 64'(n_wr - wr0), 64'(pushed - push0));
        check("locked", {63'd0, locked}, {63'd0, locked_exp});
    endtask

    initial begin
        int sel;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_err, locked}, 64'd0);
        rst = 1'b1;

        drive_frame(1'b1, -1, -1, -1, 1'b1);  // no writes: still idle
        drive_frame(1'b1, -1, -1, -1, 1'b1);  // clean capture
        drive_frame(1'b1,  2, -1, -1, 1'b0);  // overlong active line
        drive_frame(1'b1, -1, -1, -1, 1'b0);
        drive_frame(1'b1, -1,  3, -1, 1'b0);  // short line period
        drive_frame(1'b0, -1, -1, -1, 1'b0);  // disable at boundary
        drive_frame(1'b1, -1, -1, -1, 1'b0);  // nothing captured, re-enable
        drive_frame(1'b1, -1, -1, -1, 1'b0);
        drive_frame(1'b1, -1, -1,  3, 1'b0);  // reset mid-frame
        drive_frame(1'b1, -1, -1, -1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            sel = int'($urandom_range(0, 2));
            drive_frame(1'b1,
                        (sel == 1) ? int'($urandom_range(0, VA - 1)) : -1,
                        (sel == 2) ? int'($urandom_range(1, VA - 1)) : -1,
                        -1, 1'b0);
        end

        repeat (5) @(posedge clk);
        #2;
        check("wq_empty", 64'(wq.size()), 64'd0);
        check("fq_empty", 64'(fq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_capture.md
# vga_capture

Frame-capture receiver for the 640x480 VGA pixel stream, the write-side counterpart of the video-memory read path. It samples HSYNC/VSYNC/BLANK_N/RGB on the pixel clock and recovers pixel coordinates from the sync and blank timing. It writes each active pixel into a frame buffer at the same `{h_addr[9:0], v_addr[8:0]}` address layout the display side reads, and checks every frame's timing, reporting lock and error status.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_TOTAL, 800, clocks per line (hsync fall to hsync fall)
- V_TOTAL, 525, lines per frame (hsync falls between vsync falls)

Ports:
- clk  in  1  pixel clock; all sampling and outputs on the rising edge
- rst  in  1  asynchronous, active-low reset
- capture_en  in  1  capture enable; sampled only at a frame boundary
- VGA_HSYNC  in  1  horizontal sync, active low
- VGA_VSYNC  in  1  vertical sync, active low
- VGA_BLANK_N  in  1  high = active pixel
- VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
- wr_en  out  1  frame-buffer write strobe, one cycle per pixel
- wr_addr  out  19  {h[9:0], v[8:0]}
- wr_data  out  24  {R, G, B}
- frame_done  out  1  one-cycle pulse: previous frame captured with correct timing
- frame_err  out  1  one-cycle pulse: previous frame had a timing error
- locked  out  1  high after a clean frame; cleared by an error frame or reset

## Operation
- Input stage: all VGA inputs registered once into s_*; previous s_* kept as p_* for edge detection. Reset values: s/p HSYNC=1, VSYNC=1, BLANK_N=0, RGB=0. This prevents a false edge after reset.
- Frame boundary = VSYNC falling edge (s=0, p=1). Line boundary = HSYNC falling edge.
- FSM states:
  - IDLE: after reset; no writes. At a frame boundary with capture_en=1, go to CAPTURE and clear h_cnt, v_cnt, line_cnt, the period counter and err.
  - CAPTURE: at a frame boundary, evaluate the frame, then stay in CAPTURE (capture_en=1) or go to IDLE (capture_en=0).
- Pixel path in CAPTURE:
  - s_BLANK_N=1: if h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, write {h_cnt, v_cnt[8:0]} with s_RGB. Increment h_cnt, saturating at H_ACTIVE.
  - s_BLANK_N falling: if h_cnt≠H_ACTIVE or the line overran, set err. Increment v_cnt, saturating at V_ACTIVE. Clear h_cnt.
  - Pixels past H_ACTIVE are never written; they set err.
- Line period check: an 11-bit counter is cleared at each HSYNC fall. If its value ≠H_TOTAL at a fall, set err; the first fall after entering CAPTURE is exempt. line_cnt counts HSYNC falls.
- Frame evaluation at a CAPTURE frame boundary: ok = !err && v_cnt==V_ACTIVE && line_cnt==V_TOTAL.
  - ok: pulse frame_done, set locked=1.
  - otherwise: pulse frame_err, clear locked.
  - In both cases clear the counters and err for the next frame.
- A frame boundary coinciding with a line boundary or BLANK_N edge: evaluate the frame first, using the pre-update counters; the new frame starts from zero.
- Reset mid-frame: all outputs drop to 0 immediately (async). The FSM returns to IDLE, and the next write occurs only after a full frame boundary with capture_en=1.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, locked=0, state IDLE.
- All outputs are registered.
- A pixel present at the pins at edge N appears on wr_* after edge N+1 (latency 2 edges).
- frame_done/frame_err rise after edge N+1 for a VSYNC low first sampled at edge N, and last exactly one cycle.
- Throughput: one write per clock; no backpressure. The frame buffer must accept a write every cycle.

## Structure
- Shared package vga_pkg: timing constants 640/480/800/525, address width 19, and the address-concatenation function. The display side uses the same package.
- One natural sub-module: vga_sync_edge, which holds the input register, previous copy and falling-edge detect for HSYNC, VSYNC and BLANK_N.
- FSM, counters and error logic live in vga_capture.

## Test plan
- **Clean frames:** after rst release, drive two standard 640x480@800x525 frames with RGB={h[7:0],v[7:0],8'h5A}.
  - Frame 1 produces no writes.
  - Frame 2 produces exactly 307200 writes, each with wr_addr={h,v} and matching data.
  - One frame_done pulse, then locked=1.
- **Long line:** line 100 has 641 active pixels. Pixel h=640 is not written; the next boundary gives frame_err=1 and locked=0.
- **Short line period:** one line has an HSYNC period of 799 clocks. Result: frame_err pulse, and no frame_done for that frame.
- **Reset mid-frame:** assert rst low at pixel (320,240). All outputs are 0 in the same cycle. No wr_en until one full frame boundary after release.
- **Enable handling:** capture_en=0 at a boundary gives zero writes for the following frame. Raising it again resumes capture at the next boundary.
- **Latency:** inject a single pixel at a known edge N; wr_en is high exactly after edge N+1 with the correct address and data.
